// File: rtl/alu_ctrl_pkg.sv
// Shared funct codes, internal select codes and sequencer state encoding for
// the multi-cycle ALU control block.
package alu_ctrl_pkg;

    localparam logic [5:0] MULTU   = 6'b011001;
    localparam logic [5:0] DIVU    = 6'b011011;
    localparam logic [5:0] MFHI    = 6'b010000;
    localparam logic [5:0] MFLO    = 6'b010010;
    localparam logic [5:0] NOP_SEL = 6'b111110;
    localparam logic [5:0] HILO_WR = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Counter must index 0..max(limit)-1 and is never narrower than one bit.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int max_cyc;
        max_cyc = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return ($clog2(max_cyc) < 1) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/alu_multicycle_ctrl.sv
// ALU select control: passes single-cycle funct codes through and sequences
// MULTU/DIVU for a fixed cycle count followed by a one-cycle HI/LO write.
module alu_multicycle_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W    = 6,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               flush,
    output logic [FUNCT_W-1:0] alu_sel,
    output logic               busy,
    output logic               stall,
    output logic               hilo_we,
    output logic               hilo_src
);

    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    localparam logic [FUNCT_W-1:0] SEL_MULTU   = FUNCT_W'(MULTU);
    localparam logic [FUNCT_W-1:0] SEL_DIVU    = FUNCT_W'(DIVU);
    localparam logic [FUNCT_W-1:0] SEL_NOP     = FUNCT_W'(NOP_SEL);
    localparam logic [FUNCT_W-1:0] SEL_HILO_WR = FUNCT_W'(HILO_WR);
    localparam logic [CNT_W-1:0]   MUL_LAST    = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST    = CNT_W'(DIV_CYCLES - 1);

    generate
        if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cfg
            $error("alu_multicycle_ctrl: MUL_CYCLES and DIV_CYCLES must be >= 1");
        end
    endgenerate

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             op_is_div_r;
    logic             op_is_div_nxt_s;
    logic             is_mul_s;
    logic             is_div_s;
    logic [CNT_W-1:0] last_s;

    assign is_mul_s = (funct == SEL_MULTU);
    assign is_div_s = (funct == SEL_DIVU);
    assign last_s   = op_is_div_r ? DIV_LAST : MUL_LAST;
    assign busy     = (state_r != ST_IDLE);
    assign stall    = issue && busy;

    // Next-state, counter and select decode from current state and inputs.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        op_is_div_nxt_s = op_is_div_r;
        alu_sel         = SEL_NOP;
        hilo_we         = 1'b0;
        hilo_src        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue) begin
                    alu_sel = funct;
                    // A flush in the accept cycle squashes the op before it starts.
                    if ((is_mul_s || is_div_s) && !flush) begin
                        state_nxt_s     = ST_EXEC;
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        op_is_div_nxt_s = is_div_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    alu_sel = SEL_NOP;
                end
            end
            ST_EXEC: begin
                alu_sel = op_is_div_r ? SEL_DIVU : SEL_MULTU;
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == last_s) begin
                    state_nxt_s = ST_WB;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_WB: begin
                alu_sel     = SEL_HILO_WR;
                hilo_we     = !flush;
                hilo_src    = op_is_div_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_is_div_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            op_is_div_r <= op_is_div_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Bench for alu_multicycle_ctrl: two configurations driven in parallel, checked
// every cycle against an occupancy-countdown model plus directed literal checks.
module tb_alu_multicycle_ctrl;

    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_DIVU  = 6'b011011;
    localparam logic [5:0] C_MFHI  = 6'b010000;
    localparam logic [5:0] C_MFLO  = 6'b010010;
    localparam logic [5:0] C_ADD   = 6'b100000;
    localparam logic [5:0] C_NOP   = 6'b111110;
    localparam logic [5:0] C_HILO  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue;
    logic [5:0] funct;
    logic       flush;
    logic [5:0] sel_o   [2];
    logic       busy_o  [2];
    logic       stall_o [2];
    logic       we_o    [2];
    logic       src_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: rem = cycles of occupancy left (0 idle, 1 WB, >1 EXEC).
    int rem      [2];
    bit mdiv     [2];
    int lim_mul  [2] = '{32, 1};
    int lim_div  [2] = '{4, 3};
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    alu_multicycle_ctrl #(.FUNCT_W(6), .MUL_CYCLES(32), .DIV_CYCLES(4)) u_a (
        .clk(clk), .rst(rst), .issue(issue), .funct(funct), .flush(flush),
        .alu_sel(sel_o[0]), .busy(busy_o[0]), .stall(stall_o[0]),
        .hilo_we(we_o[0]), .hilo_src(src_o[0])
    );

    alu_multicycle_ctrl #(.FUNCT_W(6), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .issue(issue), .funct(funct), .flush(flush),
        .alu_sel(sel_o[1]), .busy(busy_o[1]), .stall(stall_o[1]),
        .hilo_we(we_o[1]), .hilo_src(src_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_ok <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem[i]  <= 0;
                mdiv[i] <= 1'b0;
            end else if (rem[i] == 0) begin
                if (issue && !flush && (funct == C_MULTU || funct == C_DIVU)) begin
                    mdiv[i] <= (funct == C_DIVU);
                    rem[i]  <= ((funct == C_DIVU) ? lim_div[i] : lim_mul[i]) + 1;
                end
            end else if (flush && rem[i] > 1) begin
                rem[i] <= 0;
            end else begin
                rem[i] <= rem[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] e_sel;
                logic       e_busy;
                if (rem[i] == 0)      e_sel = issue ? funct : C_NOP;
                else if (rem[i] == 1) e_sel = C_HILO;
                else                  e_sel = mdiv[i] ? C_DIVU : C_MULTU;
                e_busy = (rem[i] != 0);
                chk($sformatf("alu_sel[%0d]", i), 32'(sel_o[i]), 32'(e_sel));
                chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e_busy));
                chk($sformatf("stall[%0d]", i), 32'(stall_o[i]), 32'(issue && e_busy));
                chk($sformatf("hilo_we[%0d]", i), 32'(we_o[i]), 32'(rem[i] == 1 && !flush));
                chk($sformatf("hilo_src[%0d]", i), 32'(src_o[i]), 32'(rem[i] == 1 && mdiv[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int busy_cnt;
        int first_we;
        int we_cnt;
        rst = 1'b1; issue = 1'b0; funct = 6'd0; flush = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        chk("reset_stall", 32'(stall_o[0]), 32'd0);
        chk("reset_we", 32'(we_o[0]), 32'd0);
        chk("reset_sel", 32'(sel_o[0]), 32'(C_NOP));

        // Single-cycle pass-through
        cyc();
        issue = 1'b1; funct = C_ADD;
        #1;
        chk("add_sel", 32'(sel_o[0]), 32'h20);
        chk("add_busy", 32'(busy_o[0]), 32'd0);

        // MULTU on A (32 cycles); back-to-back MULTU on B (1 cycle)
        cyc();
        funct = C_MULTU;
        busy_cnt = 0; first_we = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k >= 4) issue = 1'b0;
            #1;
            if (busy_o[0]) busy_cnt++;
            if (we_o[0] && first_we == 0) first_we = k;
            if (k == 33) begin
                chk("mul_wb_sel", 32'(sel_o[0]), 32'h3f);
                chk("mul_wb_src", 32'(src_o[0]), 32'd0);
            end
            if (k == 1) chk("b2b_stall1", 32'(stall_o[1]), 32'd1);
            if (k == 2) chk("b2b_we", 32'(we_o[1]), 32'd1);
            if (k == 3) chk("b2b_idle", 32'(busy_o[1]), 32'd0);
            if (k == 3) chk("b2b_nostall", 32'(stall_o[1]), 32'd0);
            if (k == 4) chk("b2b_reaccept", 32'(busy_o[1]), 32'd1);
        end
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("mul_we_cycle", 32'(first_we), 32'd33);
        idle(2);

        // DIVU on A (4 cycles) with MFHI held from cycle 2
        issue = 1'b1; funct = C_DIVU;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            issue = (k >= 2);
            funct = C_MFHI;
            #1;
            if (k >= 2) chk($sformatf("div_stall_k%0d", k), 32'(stall_o[0]), 32'(k <= 5));
            if (k == 5) chk("div_we", 32'(we_o[0]), 32'd1);
            if (k == 5) chk("div_src", 32'(src_o[0]), 32'd1);
            if (k == 6) chk("mfhi_sel", 32'(sel_o[0]), 32'h10);
        end
        idle(5);

        // Flush on EXEC cycle 10
        issue = 1'b1; funct = C_MULTU;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            issue = 1'b0;
            flush = (k == 10);
            #1;
            if (k == 10) chk("flush_busy_before", 32'(busy_o[0]), 32'd1);
            if (k == 11) chk("flush_idle_after", 32'(busy_o[0]), 32'd0);
        end
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            #1;
            if (we_o[0]) we_cnt++;
        end
        chk("flush_no_we", 32'(we_cnt), 32'd0);

        // Flush coincident with WB
        issue = 1'b1; funct = C_DIVU;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            issue = 1'b0;
            flush = (k == 5);
            #1;
            if (k == 5) chk("flush_wb_we", 32'(we_o[0]), 32'd0);
            if (k == 5) chk("flush_wb_busy", 32'(busy_o[0]), 32'd1);
            if (k == 6) chk("flush_wb_idle", 32'(busy_o[0]), 32'd0);
        end
        idle(3);

        // Reset mid-EXEC together with flush and issue
        issue = 1'b1; funct = C_MULTU;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            rst   = (k == 5);
            flush = (k == 5);
            issue = (k == 5);
            #1;
            if (k == 6) chk("rst_busy", 32'(busy_o[0]), 32'd0);
            if (k == 6) chk("rst_cnt", 32'(u_a.cnt_r), 32'd0);
        end
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            #1;
            if (we_o[0]) we_cnt++;
        end
        chk("rst_no_we", 32'(we_cnt), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc();
            issue = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 5))
                0:       funct = C_MULTU;
                1:       funct = C_DIVU;
                2:       funct = C_MFHI;
                3:       funct = C_MFLO;
                4:       funct = C_ADD;
                default: funct = 6'($urandom);
            endcase
        end
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle_ctrl.md
# alu_multicycle_ctrl

Parametrised ALU control and multi-cycle sequencer for the pipelined MIPS core, sitting between the ID/EX funct field and the ALU/multiplier/divider select mux. It forwards single-cycle funct codes unchanged. It runs MULTU and DIVU for a configurable number of cycles, then issues a one-cycle HI/LO write. It stalls the pipeline while the unit is busy and supports flush-abort.

## Interface
- `FUNCT_W`, default 6: funct/select width.
- `MUL_CYCLES`, default 32: execute cycles for MULTU; must be ≥1.
- `DIV_CYCLES`, default 32: execute cycles for DIVU; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `issue` in 1: `funct` is valid this cycle (EX stage occupied).
- `funct` in FUNCT_W: instruction funct code.
- `flush` in 1: abort in-flight multi-cycle op (exception/redirect).
- `alu_sel` out FUNCT_W: select to ALU mux.
- `busy` out 1: multi-cycle op in flight.
- `stall` out 1: upstream must hold `issue`/`funct` this cycle.
- `hilo_we` out 1: one-cycle HI/LO register write strobe.
- `hilo_src` out 1: 0 = multiplier result, 1 = divider result.

## Operation
- Codes (package): MULTU 6'b011001, DIVU 6'b011011, MFHI 6'b010000, MFLO 6'b010010, NOP_SEL 6'b111110, HILO_WR 6'b111111.
- States: IDLE, EXEC, WB. Registers: state, `cnt` ($clog2(max(MUL_CYCLES,DIV_CYCLES)) bits, min 1), `op_is_div`.
- IDLE:
  - `issue`=0: `alu_sel`=NOP_SEL.
  - `issue`=1: `alu_sel`=`funct` (combinational pass-through, including unknown codes).
  - `issue` with MULTU/DIVU: accepted; go to EXEC, `cnt`←0, `op_is_div` latched.
- EXEC:
  - `alu_sel` holds MULTU or DIVU per `op_is_div`.
  - `cnt` increments each cycle.
  - When `cnt` == limit−1 (limit = DIV_CYCLES if `op_is_div` else MUL_CYCLES), go to WB.
- WB:
  - `alu_sel`=HILO_WR, `hilo_we`=1, `hilo_src`=`op_is_div`.
  - Next state IDLE unconditionally.
- `busy` = (state != IDLE).
- `stall` = `issue` && `busy`. Any instruction, including MFHI/MFLO or a second MULTU, is held until IDLE; nothing is queued.
- `flush`:
  - In EXEC: next state IDLE, `cnt`←0, no WB.
  - In WB: `hilo_we` forced 0 (combinational), state still → IDLE.
  - In IDLE with `issue` MULTU/DIVU: op not accepted; stays IDLE.
- `rst` has priority over `flush` and `issue`. It forces state IDLE, `cnt` 0, `op_is_div` 0. Mid-operation reset discards the op with no WB.
- Reset output values: `alu_sel`=NOP_SEL (`issue`=0) or `funct`, `busy`=0, `stall`=0, `hilo_we`=0, `hilo_src`=0.

## Timing
- MULTU accepted at edge T (IDLE, `issue`=1): EXEC during cycles T+1…T+MUL_CYCLES. WB (`hilo_we`=1) during cycle T+MUL_CYCLES+1. IDLE from T+MUL_CYCLES+2.
- DIVU: same, with DIV_CYCLES.
- Total occupancy is limit+1 cycles after acceptance. Back-to-back MULTU: the second is accepted at the earliest on the first IDLE cycle.
- `busy`, `stall`, `hilo_we`, `hilo_src`, and `alu_sel` are decoded from state plus inputs. They are combinational outputs with no registered-output latency.
- `alu_sel` change on a `funct` change in IDLE is zero-cycle.

## Structure
- Package `alu_ctrl_pkg`: funct constants above, NOP_SEL, HILO_WR, state enum (IDLE/EXEC/WB).
- Single module; no sub-module. `cnt` and the FSM are inline. Elaboration-time check that MUL_CYCLES and DIV_CYCLES are ≥1.

## Test plan
- Reset, then `issue`=1 with ADD 6'b100000 → `alu_sel`=6'b100000 same cycle; `busy`=0; `hilo_we` never 1.
- MULTU issued, default params → `busy`=1 for 33 cycles; `hilo_we`=1 exactly on the 33rd cycle after acceptance with `hilo_src`=0; `alu_sel`=6'b111111 on that cycle only.
- DIVU with DIV_CYCLES=4 → WB on cycle 5 after acceptance with `hilo_src`=1; MFHI issued on cycle 2 → `stall`=1 through WB, accepted in the first IDLE cycle with `alu_sel`=6'b010000.
- MULTU, then `flush` on EXEC cycle 10 → IDLE next cycle; no `hilo_we` pulse within 40 cycles. `flush` coincident with WB → `hilo_we`=0.
- `rst` asserted mid-EXEC together with `flush` and `issue` → next cycle IDLE, `busy`=0, `cnt`=0, no WB.
- MUL_CYCLES=1 → EXEC 1 cycle, WB next; back-to-back MULTU accepted again exactly 3 cycles after the first.
